// File: rtl/wide_add_sequencer.sv
// Multi-word add/subtract sequencer: streams NUM_WORDS 32-bit words through an
// external 32-bit carry adder, least-significant word first, one word per clock.
module wide_add_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start_In,
  output logic                    Ready_Out,
  input  logic [32*NUM_WORDS-1:0] A_In,
  input  logic [32*NUM_WORDS-1:0] B_In,
  input  logic                    C_In,
  input  logic                    Sub_In,
  output logic [31:0]             Add_A_Out,
  output logic [31:0]             Add_B_Out,
  output logic                    Add_Cin_Out,
  input  logic [31:0]             Add_Sum_In,
  input  logic                    Add_Cout_In,
  output logic [32*NUM_WORDS-1:0] Sum_Out,
  output logic                    C_Out,
  output logic                    Overflow_Out,
  output logic                    Done_Out,
  input  logic                    Ack_In
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [NUM_WORDS-1:0][31:0] a_q, b_q, sum_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       carry_q, c_q, ovf_q;
  logic                       accept, step, last_step;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    Ready_Out  = 1'b0;
    Done_Out   = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    unique case (state)
      IDLE: begin
        Ready_Out = 1'b1;
        if (Start_In) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        Done_Out = 1'b1;
        if (Ack_In) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: operand holding registers carry no reset; they are always loaded before use.
  always_ff @(posedge Clk) begin
    if (accept) begin
      a_q <= A_In;
      b_q <= Sub_In ? ~B_In : B_In;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= Sub_In | C_In;
    end else if (step) begin
      sum_q[idx_q] <= Add_Sum_In;
      carry_q      <= Add_Cout_In;
      idx_q        <= last_step ? '0 : idx_q + IDX_W'(1);
      if (last_step) begin
        c_q   <= Add_Cout_In;
        // Signed overflow: like-signed operands producing a result of the other sign.
        ovf_q <= (a_q[NUM_WORDS-1][31] == b_q[NUM_WORDS-1][31]) &&
                 (Add_Sum_In[31] != a_q[NUM_WORDS-1][31]);
      end
    end
  end

  // Adder drive comes only from registers, and is forced to zero outside RUN.
  assign Add_A_Out   = step ? a_q[idx_q] : '0;
  assign Add_B_Out   = step ? b_q[idx_q] : '0;
  assign Add_Cin_Out = step & carry_q;

  assign Sum_Out      = sum_q;
  assign C_Out        = c_q;
  assign Overflow_Out = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (NUM_WORDS=4) with a behavioural 32-bit
// adder closing the external adder loop.
module tb_wide_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic         Clk = 1'b0;
  logic         Rst, Start_In, C_In, Sub_In, Ack_In;
  logic [W-1:0] A_In, B_In, Sum_Out;
  logic         Ready_Out, Done_Out, C_Out, Overflow_Out;
  logic [31:0]  Add_A_Out, Add_B_Out, Add_Sum_In;
  logic         Add_Cin_Out, Add_Cout_In;
  logic [32:0]  add_full;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_c;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  wide_add_sequencer #(.NUM_WORDS(NW)) dut (
    .Clk(Clk), .Rst(Rst), .Start_In(Start_In), .Ready_Out(Ready_Out),
    .A_In(A_In), .B_In(B_In), .C_In(C_In), .Sub_In(Sub_In),
    .Add_A_Out(Add_A_Out), .Add_B_Out(Add_B_Out), .Add_Cin_Out(Add_Cin_Out),
    .Add_Sum_In(Add_Sum_In), .Add_Cout_In(Add_Cout_In),
    .Sum_Out(Sum_Out), .C_Out(C_Out), .Overflow_Out(Overflow_Out),
    .Done_Out(Done_Out), .Ack_In(Ack_In)
  );

  // External 32-bit carry adder
  assign add_full    = {1'b0, Add_A_Out} + {1'b0, Add_B_Out} + {32'd0, Add_Cin_Out};
  assign Add_Sum_In  = add_full[31:0];
  assign Add_Cout_In = add_full[32];

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepts one operation and waits for Done, checking latency and results.
  task automatic run_op(input vec_t v);
    int n;
    @(negedge Clk);
    A_In = v.a; B_In = v.b; C_In = v.c_in; Sub_In = v.sub; Start_In = 1'b1;
    @(posedge Clk); #1;
    Start_In = 1'b0;
    // Operand changes after acceptance must not matter.
    A_In = ~v.a; B_In = ~v.b; C_In = ~v.c_in; Sub_In = ~v.sub;
    check({v.name, " ready_low_in_run"}, W'(Ready_Out), W'(0));
    check({v.name, " add_a_word0"}, W'(Add_A_Out), W'(v.a[31:0]));
    check({v.name, " add_cin_word0"}, W'(Add_Cin_Out), W'(v.sub | v.c_in));
    n = 0;
    while (!Done_Out && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check({v.name, " latency"}, W'(n), W'(NW));
    check({v.name, " sum"}, Sum_Out, v.exp_sum);
    check({v.name, " c_out"}, W'(C_Out), W'(v.exp_c));
    check({v.name, " overflow"}, W'(Overflow_Out), W'(v.exp_ovf));
    check({v.name, " adder_idle_in_done"}, W'({Add_A_Out, Add_B_Out, Add_Cin_Out}), W'(0));
    @(negedge Clk); Ack_In = 1'b1;
    @(posedge Clk); #1;
    Ack_In = 1'b0;
    check({v.name, " ready_after_ack"}, W'(Ready_Out), W'(1));
    check({v.name, " sum_retained_idle"}, Sum_Out, v.exp_sum);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         stable;
    int           n;
    bit           done_seen;

    vecs[0] = '{"add_ones_cin", {W{1'b1}}, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0};
    vecs[1] = '{"add_word_carry", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[2] = '{"add_pos_ovf", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{"sub_5_7", 128'd5, 128'd7, 1'b0, 1'b1,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub_7_5", 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0};
    vecs[5] = '{"sub_min_ovf", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b0, 1'b1,
                128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{"sub_zero_cin_ignored", '0, '0, 1'b1, 1'b1, '0, 1'b1, 1'b0};
    vecs[7] = '{"add_alt_words", 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000,
                128'h0000_0001_FFFF_FFFF_0000_0001_FFFF_FFFF, 1'b1, 1'b0,
                128'h0000_0001_0000_0000_0000_0001_0000_0000, 1'b1, 1'b0};

    Rst = 1'b1; Start_In = 1'b0; Ack_In = 1'b0; C_In = 1'b0; Sub_In = 1'b0;
    A_In = '0; B_In = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); Rst = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check("reset ready", W'(Ready_Out), W'(1));
    check("reset done", W'(Done_Out), W'(0));
    check("reset sum", Sum_Out, '0);
    check("reset c_out_ovf", W'({C_Out, Overflow_Out}), W'(0));
    check("reset adder_outputs", W'({Add_A_Out, Add_B_Out, Add_Cin_Out}), W'(0));

    foreach (vecs[i]) run_op(vecs[i]);

    // Ack held low with Start pulses: DONE must hold its result.
    @(negedge Clk);
    A_In = 128'd7; B_In = 128'd5; Sub_In = 1'b1; C_In = 1'b0; Start_In = 1'b1;
    @(posedge Clk); #1;
    Start_In = 1'b0;
    n = 0;
    while (!Done_Out && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("hold reached_done", W'(Done_Out), W'(1));
    held_sum = Sum_Out;
    check("hold sum", held_sum, 128'd2);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      Start_In = i[0]; A_In = {4{$urandom}}; B_In = {4{$urandom}}; Sub_In = ~Sub_In;
      @(posedge Clk); #1;
      if (!Done_Out || Ready_Out || Sum_Out !== held_sum || !C_Out || Overflow_Out ||
          Add_A_Out != 0 || Add_Cin_Out) stable = 1'b0;
    end
    check("hold outputs_stable", W'(stable), W'(1));
    @(negedge Clk); Start_In = 1'b0; Ack_In = 1'b1;
    @(posedge Clk); #1;
    Ack_In = 1'b0;
    check("hold ready_after_ack", W'(Ready_Out), W'(1));
    check("hold done_dropped", W'(Done_Out), W'(0));

    // Back-to-back: Start held high through Ack starts the next op one edge later.
    @(negedge Clk);
    A_In = 128'd100; B_In = 128'd23; Sub_In = 1'b0; C_In = 1'b0; Start_In = 1'b1;
    @(posedge Clk); #1;
    n = 0;
    while (!Done_Out && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("b2b first_sum", Sum_Out, 128'd123);
    @(negedge Clk); Ack_In = 1'b1; A_In = 128'd50; B_In = 128'd8; Sub_In = 1'b1;
    @(posedge Clk); #1;
    Ack_In = 1'b0;
    check("b2b idle_after_ack", W'(Ready_Out), W'(1));
    @(posedge Clk); #1;
    Start_In = 1'b0;
    check("b2b restarted", W'(Ready_Out), W'(0));
    n = 0;
    while (!Done_Out && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("b2b second_latency", W'(n), W'(NW));
    check("b2b second_sum", Sum_Out, 128'd42);
    @(negedge Clk); Ack_In = 1'b1;
    @(posedge Clk); #1;
    Ack_In = 1'b0;

    // Reset in RUN at word index 2 abandons the operation.
    @(negedge Clk);
    A_In = 128'd1; B_In = 128'd1; Sub_In = 1'b0; C_In = 1'b0; Start_In = 1'b1;
    @(posedge Clk); #1;
    Start_In = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_run at_index2", W'(Add_A_Out), W'(0));
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
    check("rst_run ready", W'(Ready_Out), W'(1));
    check("rst_run adder_zero", W'({Add_A_Out, Add_B_Out, Add_Cin_Out}), W'(0));
    @(negedge Clk); Rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (Done_Out) done_seen = 1'b1;
    end
    check("rst_run no_done", W'(done_seen), W'(0));
    check("rst_run sum_cleared", Sum_Out, '0);
    run_op(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
